status_value_packer: RTL and testbench

- Downstream drain stage for status_value_vector.
- Pulls entries from the vector through its value_o/valid_o/pull_i interface and packs PACK consecutive entries into one wide word.
- Emits the word on a valid/ready handshake toward the commit/log path.
- A partial word is emitted on an idle timeout or on an explicit flush, so entries never stall indefinitely.

---
 rtl/status_value_packer_pkg.sv | 26 ++
 rtl/status_value_timer.sv | 45 ++++
 rtl/status_value_packer.sv | 127 ++++++++++++
 tb/tb_status_value_packer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/status_value_packer_pkg.sv
// -----------------------------------------------------------------------------
// status_value_packer_pkg
//   Shared definitions for the status_value packer and its idle timer:
//   the packer state encoding and a constant clog2 helper that is usable in
//   parameter/localparam expressions.
// -----------------------------------------------------------------------------
package status_value_packer_pkg;

    // Packer states, 2-bit encoding.
    typedef enum logic [1:0] {
        SV_PK_IDLE = 2'd0,
        SV_PK_FILL = 2'd1,
        SV_PK_HOLD = 2'd2
    } sv_pk_state_t;

    // Ceiling log2 for elaboration-time sizing; sv_clog2(1) = 0.
    function automatic int sv_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/status_value_timer.sv
// -----------------------------------------------------------------------------
// status_value_timer
//   Idle counter bounded by TIMEOUT. Counts enabled cycles from 0 and stops
//   at TIMEOUT-1, where expired_o is asserted. Clear has priority over enable.
//
// Ports:
//   clk_i      clock
//   rsn_i      synchronous active-low reset (counter to 0)
//   clr_i      clear the counter to 0
//   en_i       count one idle cycle
//   expired_o  counter has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module status_value_timer
    import status_value_packer_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rsn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // TIMEOUT == 1 still needs a 1-bit counter (it just sits at 0).
    localparam int TW = (TIMEOUT > 1) ? sv_clog2(TIMEOUT) : 1;

    logic [TW-1:0] r_cnt;
    logic          w_expired;

    assign w_expired = (r_cnt == TW'(TIMEOUT - 1));
    assign expired_o = w_expired;

    // Saturate at TIMEOUT-1 so the counter never wraps if the owner lingers.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !w_expired) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/status_value_packer.sv
// -----------------------------------------------------------------------------
// status_value_packer
//   Drain stage for status_value_vector. Pulls entries one per cycle and packs
//   PACK of them into a wide word (entry 0 = oldest, at the LSBs). The word is
//   offered on a valid/ready handshake; a partial word goes out after TIMEOUT
//   idle cycles or on flush_i.
//
// Ports:
//   clk_i, rsn_i   clock, synchronous active-low reset
//   sv_valid_i     vector has an entry available
//   sv_value_i     oldest vector entry
//   sv_pull_o      pop the oldest entry (captured in the same cycle)
//   flush_i        emit the partial word being filled
//   word_o         packed word, lane k at [k*WIDTH +: WIDTH]
//   count_o        number of valid lanes in word_o
//   word_valid_o   word_o/count_o valid (HOLD)
//   word_ready_i   downstream accepts the word
// -----------------------------------------------------------------------------
module status_value_packer
    import status_value_packer_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int PACK    = 8,
    parameter int TIMEOUT = 16,
    localparam int CNT_W  = sv_clog2(PACK + 1)
) (
    input  logic                    clk_i,
    input  logic                    rsn_i,
    input  logic                    sv_valid_i,
    input  logic [WIDTH-1:0]        sv_value_i,
    output logic                    sv_pull_o,
    input  logic                    flush_i,
    output logic [PACK*WIDTH-1:0]   word_o,
    output logic [CNT_W-1:0]        count_o,
    output logic                    word_valid_o,
    input  logic                    word_ready_i
);

    sv_pk_state_t          r_state;
    sv_pk_state_t          w_state_next;
    logic [PACK*WIDTH-1:0] r_word;
    logic [PACK*WIDTH-1:0] w_word_next;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_next;
    logic [CNT_W-1:0]      w_count_inc;
    logic                  w_pull;
    logic                  w_accept;
    logic                  w_expired;

    // Never pull in HOLD (the word is parked) or while reset is asserted.
    assign w_pull      = rsn_i & sv_valid_i & (r_state != SV_PK_HOLD);
    assign w_accept    = (r_state == SV_PK_HOLD) & word_ready_i;
    assign w_count_inc = r_count + CNT_W'(1);

    // Timer runs only on pull-free FILL cycles; any pull or non-FILL state
    // restarts it, so it is already 0 when the next word starts filling.
    status_value_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rsn_i     (rsn_i),
        .clr_i     (w_pull | (r_state != SV_PK_FILL)),
        .en_i      ((r_state == SV_PK_FILL) & ~w_pull),
        .expired_o (w_expired)
    );

    // Lane write: the pulled value lands in lane r_count; accepted words are
    // wiped so unused lanes of the next partial word read as 0.
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
        assign w_word_next[gi*WIDTH +: WIDTH] =
            w_accept                              ? '0 :
            (w_pull && (r_count == CNT_W'(gi)))   ? sv_value_i :
                                                    r_word[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            SV_PK_IDLE: begin
                if (w_pull) begin
                    w_count_next = w_count_inc;
                    w_state_next = (w_count_inc == CNT_W'(PACK)) ? SV_PK_HOLD : SV_PK_FILL;
                end
            end
            SV_PK_FILL: begin
                // A pull always wins over the timeout; flush includes the pull.
                if (w_pull) begin
                    w_count_next = w_count_inc;
                    if ((w_count_inc == CNT_W'(PACK)) || flush_i) begin
                        w_state_next = SV_PK_HOLD;
                    end
                end else if (flush_i || w_expired) begin
                    w_state_next = SV_PK_HOLD;
                end
            end
            SV_PK_HOLD: begin
                if (word_ready_i) begin
                    w_count_next = '0;
                    w_state_next = SV_PK_IDLE;
                end
            end
            default: begin
                w_count_next = '0;
                w_state_next = SV_PK_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            r_state <= SV_PK_IDLE;
            r_word  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_word  <= w_word_next;
            r_count <= w_count_next;
        end
    end

    assign sv_pull_o    = w_pull;
    assign word_o       = r_word;
    assign count_o      = r_count;
    assign word_valid_o = (r_state == SV_PK_HOLD);

endmodule

// File: tb/tb_status_value_packer.sv
// -----------------------------------------------------------------------------
// tb_status_value_packer
//   Directed bench for status_value_packer with WIDTH=4, PACK=4, TIMEOUT=5.
//   "Cycle n" is the interval after the n-th rising edge of a test; inputs are
//   set 1 ns after the edge and outputs are sampled 3 ns after the edge.
// -----------------------------------------------------------------------------
module tb_status_value_packer;

    localparam int WIDTH   = 4;
    localparam int PACK    = 4;
    localparam int TIMEOUT = 5;
    localparam int CNT_W   = 3;

    logic                  clk_i = 1'b0;
    logic                  rsn_i;
    logic                  sv_valid_i;
    logic [WIDTH-1:0]      sv_value_i;
    logic                  sv_pull_o;
    logic                  flush_i;
    logic [PACK*WIDTH-1:0] word_o;
    logic [CNT_W-1:0]      count_o;
    logic                  word_valid_o;
    logic                  word_ready_i;

    int n_pass  = 0;
    int n_total = 0;

    status_value_packer #(
        .WIDTH   (WIDTH),
        .PACK    (PACK),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rsn_i        (rsn_i),
        .sv_valid_i   (sv_valid_i),
        .sv_value_i   (sv_value_i),
        .sv_pull_o    (sv_pull_o),
        .flush_i      (flush_i),
        .word_o       (word_o),
        .count_o      (count_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rsn_i = 1'b0; sv_valid_i = 1'b0; sv_value_i = '0;
        flush_i = 1'b0; word_ready_i = 1'b0;
        tick();
        rsn_i = 1'b1;
    endtask

    task automatic test_reset();
        rsn_i = 1'b0; sv_valid_i = 1'b1; sv_value_i = 4'h9;
        flush_i = 1'b0; word_ready_i = 1'b0;
        #2;
        n_total++;
        if (sv_pull_o !== 1'b0) $display("FAIL reset_pull_gate: got %b want 0", sv_pull_o);
        else n_pass++;
        tick();
        #2;
        n_total++;
        if (word_valid_o !== 1'b0 || count_o !== 3'd0 || word_o !== 16'h0000)
            $display("FAIL reset_state: valid=%b count=%0d word=%h want 0/0/0000", word_valid_o, count_o, word_o);
        else n_pass++;
        $display("test_reset: valid=%b count=%0d word=%h", word_valid_o, count_o, word_o);
        sv_valid_i = 1'b0;
        rsn_i = 1'b1;
    endtask

    task automatic test_full_word();
        do_reset();
        word_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sv_valid_i = 1'b1; sv_value_i = 4'(c + 1);
            #2;
            n_total++;
            if (sv_pull_o !== 1'b1 || word_valid_o !== 1'b0)
                $display("FAIL full_pull_c%0d: pull=%b valid=%b want 1/0", c, sv_pull_o, word_valid_o);
            else n_pass++;
            tick();
        end
        sv_value_i = 4'h5;
        #2;
        n_total++;
        if (word_valid_o !== 1'b1 || word_o !== 16'h4321 || count_o !== 3'd4 || sv_pull_o !== 1'b0)
            $display("FAIL full_word_c4: valid=%b word=%h count=%0d pull=%b want 1/4321/4/0",
                     word_valid_o, word_o, count_o, sv_pull_o);
        else n_pass++;
        $display("test_full_word: word=%h count=%0d", word_o, count_o);
        tick();
        #2;
        n_total++;
        if (sv_pull_o !== 1'b1 || word_valid_o !== 1'b0)
            $display("FAIL full_bubble_c5: pull=%b valid=%b want 1/0", sv_pull_o, word_valid_o);
        else n_pass++;
        tick();
        n_total++;
        if (word_o !== 16'h0005 || count_o !== 3'd1)
            $display("FAIL full_next_word: word=%h count=%0d want 0005/1", word_o, count_o);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        word_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sv_valid_i = 1'b1; sv_value_i = 4'(c + 1);
            tick();
        end
        for (int c = 4; c < 8; c++) begin
            word_ready_i = (c == 7);
            sv_value_i = 4'hE;
            #2;
            n_total++;
            if (word_valid_o !== 1'b1 || word_o !== 16'h4321 || count_o !== 3'd4 || sv_pull_o !== 1'b0)
                $display("FAIL bp_hold_c%0d: valid=%b word=%h count=%0d pull=%b want 1/4321/4/0",
                         c, word_valid_o, word_o, count_o, sv_pull_o);
            else n_pass++;
            $display("test_backpressure c%0d: ready=%b word=%h", c, word_ready_i, word_o);
            tick();
        end
        word_ready_i = 1'b0;
        #2;
        n_total++;
        if (word_valid_o !== 1'b0 || count_o !== 3'd0 || word_o !== 16'h0000 || sv_pull_o !== 1'b1)
            $display("FAIL bp_idle_c8: valid=%b count=%0d word=%h pull=%b want 0/0/0000/1",
                     word_valid_o, count_o, word_o, sv_pull_o);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        word_ready_i = 1'b0;
        sv_valid_i = 1'b1; sv_value_i = 4'hA; tick();
        sv_value_i = 4'hB; tick();
        sv_valid_i = 1'b0;
        for (int c = 2; c < 7; c++) begin
            #2;
            n_total++;
            if (word_valid_o !== 1'b0) $display("FAIL timeout_early_c%0d: valid=%b want 0", c, word_valid_o);
            else n_pass++;
            tick();
        end
        #2;
        n_total++;
        if (word_valid_o !== 1'b1 || word_o !== 16'h00BA || count_o !== 3'd2)
            $display("FAIL timeout_c7: valid=%b word=%h count=%0d want 1/00BA/2", word_valid_o, word_o, count_o);
        else n_pass++;
        $display("test_timeout: word=%h count=%0d", word_o, count_o);
    endtask

    task automatic test_timeout_race();
        do_reset();
        word_ready_i = 1'b0;
        sv_valid_i = 1'b1; sv_value_i = 4'h1; tick();
        sv_valid_i = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        // Cycle 5: timer is at TIMEOUT-1, the pull must win.
        sv_valid_i = 1'b1; sv_value_i = 4'h2;
        #2;
        n_total++;
        if (sv_pull_o !== 1'b1) $display("FAIL race_pull_c5: pull=%b want 1", sv_pull_o);
        else n_pass++;
        tick();
        sv_valid_i = 1'b0;
        // Timer restarted at 0 in cycle 6, so it expires in cycle 10.
        for (int c = 6; c < 11; c++) begin
            #2;
            n_total++;
            if (word_valid_o !== 1'b0 || count_o !== 3'd2)
                $display("FAIL race_no_emit_c%0d: valid=%b count=%0d want 0/2", c, word_valid_o, count_o);
            else n_pass++;
            tick();
        end
        #2;
        n_total++;
        if (word_valid_o !== 1'b1 || word_o !== 16'h0021 || count_o !== 3'd2)
            $display("FAIL race_emit_c11: valid=%b word=%h count=%0d want 1/0021/2", word_valid_o, word_o, count_o);
        else n_pass++;
        $display("test_timeout_race: word=%h count=%0d", word_o, count_o);
    endtask

    task automatic test_flush();
        do_reset();
        word_ready_i = 1'b0;
        flush_i = 1'b1; sv_valid_i = 1'b0;
        tick();
        flush_i = 1'b0;
        #2;
        n_total++;
        if (word_valid_o !== 1'b0 || count_o !== 3'd0)
            $display("FAIL flush_idle: valid=%b count=%0d want 0/0", word_valid_o, count_o);
        else n_pass++;
        sv_valid_i = 1'b1; sv_value_i = 4'h3;
        tick();
        sv_value_i = 4'h7; flush_i = 1'b1;
        #2;
        n_total++;
        if (sv_pull_o !== 1'b1) $display("FAIL flush_pull: pull=%b want 1", sv_pull_o);
        else n_pass++;
        tick();
        flush_i = 1'b0;
        #2;
        n_total++;
        if (word_valid_o !== 1'b1 || word_o !== 16'h0073 || count_o !== 3'd2 || sv_pull_o !== 1'b0)
            $display("FAIL flush_hold: valid=%b word=%h count=%0d pull=%b want 1/0073/2/0",
                     word_valid_o, word_o, count_o, sv_pull_o);
        else n_pass++;
        $display("test_flush: word=%h count=%0d", word_o, count_o);
    endtask

    // Continues from test_flush, which leaves an un-accepted word in HOLD.
    task automatic test_reset_hold();
        rsn_i = 1'b0; sv_valid_i = 1'b1;
        #2;
        n_total++;
        if (sv_pull_o !== 1'b0 || word_valid_o !== 1'b1)
            $display("FAIL rst_hold_during: pull=%b valid=%b want 0/1", sv_pull_o, word_valid_o);
        else n_pass++;
        tick();
        rsn_i = 1'b1;
        #2;
        n_total++;
        if (word_valid_o !== 1'b0 || count_o !== 3'd0 || word_o !== 16'h0000 || sv_pull_o !== 1'b1)
            $display("FAIL rst_hold_after: valid=%b count=%0d word=%h pull=%b want 0/0/0000/1",
                     word_valid_o, count_o, word_o, sv_pull_o);
        else n_pass++;
        $display("test_reset_hold: valid=%b count=%0d word=%h", word_valid_o, count_o, word_o);
        sv_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_backpressure();
        test_timeout();
        test_timeout_race();
        test_flush();
        test_reset_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
